fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_wr_arbiter.sv | 145 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready requesters.
// Latency: one bubble cycle per packet (IDLE arbitration), then one beat per cycle in BURST.
// Backpressure: fifo_full deasserts the granted req_ready and fifo_wr_en; grant and beat count hold.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16,
  localparam int ID_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic [ID_WIDTH-1:0]           fifo_wr_id,
  input  logic                          fifo_full,
  output logic                          busy,
  output logic [ID_WIDTH-1:0]           grant_id
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0] grant_id_q, grant_id_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic                busy_q, busy_d;

  logic                arb_found;
  logic [ID_WIDTH-1:0] arb_idx;
  logic                gnt_valid;
  logic                gnt_last;
  logic [DATA_WIDTH-1:0] gnt_data;
  logic                in_burst;
  logic                burst_end;

  // Index ptr+off modulo NUM_REQ; off is always below NUM_REQ so one subtraction suffices.
  function automatic logic [ID_WIDTH-1:0] wrap_add(input logic [ID_WIDTH-1:0] ptr, input int off);
    int s;
    s = int'(ptr) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_WIDTH'(s);
  endfunction

  // Round-robin pick: first valid requester scanning upward from rr_ptr.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!arb_found && req_valid[wrap_add(rr_ptr_q, i)]) begin
        arb_found = 1'b1;
        arb_idx   = wrap_add(rr_ptr_q, i);
      end
    end
  end

  // Select the granted requester's valid/last/data; data follows grant_id even in IDLE.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_last  = 1'b0;
    gnt_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == ID_WIDTH'(i)) begin
        gnt_valid = req_valid[i];
        gnt_last  = req_last[i];
        gnt_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Handshake outputs; nothing transfers while reset is asserted.
  always_comb begin
    in_burst   = (state_q == ST_BURST);
    req_ready  = '0;
    fifo_wr_en = in_burst && gnt_valid && !fifo_full && !rst;
    if (in_burst && !fifo_full && !rst) begin
      req_ready[grant_id_q] = 1'b1;
    end
    burst_end = fifo_wr_en && (gnt_last || (beat_cnt_q == CNT_W'(MAX_BURST - 1)));
  end

  // Next-state logic: arbitrate in IDLE, count beats and close the packet in BURST.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    beat_cnt_d = beat_cnt_q;
    busy_d     = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_found) begin
          grant_id_d = arb_idx;
          beat_cnt_d = '0;
          state_d    = ST_BURST;
          busy_d     = 1'b1;
        end
      end
      ST_BURST: begin
        if (burst_end) begin
          rr_ptr_d   = wrap_add(grant_id_q, 1);
          beat_cnt_d = '0;
          state_d    = ST_IDLE;
          busy_d     = 1'b0;
        end else if (fifo_wr_en) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      beat_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      beat_cnt_q <= beat_cnt_d;
      busy_q     <= busy_d;
    end
  end

  assign fifo_wr_data = gnt_data;
  assign fifo_wr_id   = grant_id_q;
  assign grant_id     = grant_id_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed testbench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=32, MAX_BURST=4).
// Requesters are modelled as packet sources; writes are logged with their cycle number.
// Stimulus changes on the falling edge, outputs are sampled 1 ns later.
module tb_fifo_wr_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_last;
  logic [3:0]   req_ready;
  logic         fifo_wr_en;
  logic [31:0]  fifo_wr_data;
  logic [1:0]   fifo_wr_id;
  logic         fifo_full;
  logic         busy;
  logic [1:0]   grant_id;

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_wr_id(fifo_wr_id),
    .fifo_full(fifo_full), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;

  int pkts [4];
  int len  [4];
  int sent [4];
  int bcnt [4];
  int base [4];
  bit gap  [4];
  bit full_m;

  logic        cur_wr_en, cur_busy;
  logic [31:0] cur_dat;
  logic [1:0]  cur_id, cur_gid;
  logic [3:0]  cur_rdy;

  int lg_id [$];
  int lg_dat[$];
  int lg_cyc[$];

  task automatic clear_model();
    for (int i = 0; i < 4; i++) begin
      pkts[i] = 0; len[i] = 1; sent[i] = 0; bcnt[i] = 0; base[i] = 0; gap[i] = 1'b0;
    end
    full_m = 1'b0;
    lg_id.delete(); lg_dat.delete(); lg_cyc.delete();
  endtask

  // One clock cycle: drive from the model, sample, log writes, advance the model.
  task automatic step();
    for (int i = 0; i < 4; i++) begin
      req_valid[i]            = (pkts[i] > 0) && !gap[i];
      req_data[i*32 +: 32]    = 32'(base[i] + bcnt[i]);
      req_last[i]             = (sent[i] == len[i] - 1);
    end
    fifo_full = full_m;
    #1;
    cur_wr_en = fifo_wr_en; cur_busy = busy; cur_dat = fifo_wr_data;
    cur_id = fifo_wr_id; cur_gid = grant_id; cur_rdy = req_ready;
    if (fifo_wr_en) begin
      lg_id.push_back(int'(fifo_wr_id));
      lg_dat.push_back(int'(fifo_wr_data));
      lg_cyc.push_back(cyc);
    end
    for (int i = 0; i < 4; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        bcnt[i]++;
        sent[i]++;
        if (sent[i] == len[i]) begin
          sent[i] = 0;
          pkts[i]--;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_model();
    for (int i = 0; i < 4; i++) pkts[i] = 1;
    step();
    step();
    ntests++; if (cur_busy !== 1'b0) begin nfail++; $display("FAIL reset_busy got %0b want 0", cur_busy); end
    ntests++; if (cur_wr_en !== 1'b0) begin nfail++; $display("FAIL reset_wr_en got %0b want 0", cur_wr_en); end
    ntests++; if (cur_rdy !== 4'b0000) begin nfail++; $display("FAIL reset_ready got %b want 0000", cur_rdy); end
    ntests++; if (cur_gid !== 2'd0) begin nfail++; $display("FAIL reset_grant_id got %0d want 0", cur_gid); end
    rst = 1'b0;
    clear_model();
    step();
    ntests++; if (cur_busy !== 1'b0 || cur_gid !== 2'd0) begin
      nfail++; $display("FAIL post_reset_idle busy=%0b gid=%0d want 0/0", cur_busy, cur_gid);
    end
  endtask

  task automatic test_single_requester();
    clear_model();
    pkts[2] = 1; len[2] = 3; base[2] = 32'hA0;
    step();
    ntests++; if (cur_wr_en !== 1'b0 || cur_busy !== 1'b0) begin
      nfail++; $display("FAIL single_bubble wr_en=%0b busy=%0b want 0/0", cur_wr_en, cur_busy);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      ntests++; if (cur_wr_en !== 1'b1 || cur_id !== 2'd2 || cur_dat !== 32'(32'hA0 + k) || cur_busy !== 1'b1) begin
        nfail++; $display("FAIL single_beat%0d wr_en=%0b id=%0d data=%h busy=%0b want 1/2/%h/1",
                          k, cur_wr_en, cur_id, cur_dat, cur_busy, 32'hA0 + k);
      end
    end
    step();
    ntests++; if (cur_busy !== 1'b0 || cur_wr_en !== 1'b0) begin
      nfail++; $display("FAIL single_end busy=%0b wr_en=%0b want 0/0", cur_busy, cur_wr_en);
    end
  endtask

  // rr_ptr is 3 after the single-requester packet, so the rotation starts at 3.
  task automatic test_round_robin();
    int t0;
    int exp_id;
    clear_model();
    for (int i = 0; i < 4; i++) begin pkts[i] = 2; len[i] = 1; base[i] = i << 4; end
    pkts[3] = 3;
    t0 = cyc;
    run(18);
    ntests++; if (lg_id.size() !== 9) begin nfail++; $display("FAIL rr_count got %0d want 9", lg_id.size()); end
    for (int k = 0; k < 9 && k < lg_id.size(); k++) begin
      exp_id = (3 + k) % 4;
      ntests++; if (lg_id[k] !== exp_id || lg_cyc[k] !== t0 + 1 + 2*k || lg_dat[k] !== (exp_id << 4) + k/4) begin
        nfail++; $display("FAIL rr_grant%0d id=%0d cyc=%0d data=%h want %0d/%0d/%h",
                          k, lg_id[k], lg_cyc[k] - t0, lg_dat[k], exp_id, 1 + 2*k, (exp_id << 4) + k/4);
      end
    end
  endtask

  task automatic test_max_burst();
    int t0, p;
    int seg_id [6] = '{1, 3, 1, 3, 1, 3};
    int seg_b0 [6] = '{0, 0, 4, 4, 8, 8};
    int seg_n  [6] = '{4, 4, 4, 4, 2, 2};
    int seg_c  [6] = '{1, 6, 11, 16, 21, 24};
    clear_model();
    pkts[1] = 1; len[1] = 10; base[1] = 32'h100;
    pkts[3] = 1; len[3] = 10; base[3] = 32'h300;
    t0 = cyc;
    run(26);
    ntests++; if (lg_id.size() !== 20) begin nfail++; $display("FAIL burst_count got %0d want 20", lg_id.size()); end
    p = 0;
    for (int s = 0; s < 6; s++) begin
      for (int b = 0; b < seg_n[s]; b++) begin
        if (p < lg_id.size()) begin
          ntests++;
          if (lg_id[p] !== seg_id[s] || lg_dat[p] !== (seg_id[s] << 8) + seg_b0[s] + b || lg_cyc[p] !== t0 + seg_c[s] + b) begin
            nfail++; $display("FAIL burst_beat%0d id=%0d data=%h cyc=%0d want %0d/%h/%0d", p, lg_id[p], lg_dat[p],
                              lg_cyc[p] - t0, seg_id[s], (seg_id[s] << 8) + seg_b0[s] + b, seg_c[s] + b);
          end
        end
        p++;
      end
    end
  endtask

  task automatic test_backpressure();
    int t0;
    int exp_c [4] = '{1, 2, 8, 9};
    clear_model();
    pkts[0] = 1; len[0] = 4; base[0] = 32'hB0;
    t0 = cyc;
    run(3);
    full_m = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      ntests++; if (cur_wr_en !== 1'b0 || cur_rdy !== 4'b0000 || cur_busy !== 1'b1 || cur_gid !== 2'd0) begin
        nfail++; $display("FAIL bp_stall%0d wr_en=%0b rdy=%b busy=%0b gid=%0d want 0/0000/1/0",
                          k, cur_wr_en, cur_rdy, cur_busy, cur_gid);
      end
    end
    full_m = 1'b0;
    run(3);
    ntests++; if (lg_id.size() !== 4) begin nfail++; $display("FAIL bp_count got %0d want 4", lg_id.size()); end
    for (int k = 0; k < 4 && k < lg_id.size(); k++) begin
      ntests++; if (lg_id[k] !== 0 || lg_dat[k] !== 32'hB0 + k || lg_cyc[k] !== t0 + exp_c[k]) begin
        nfail++; $display("FAIL bp_beat%0d id=%0d data=%h cyc=%0d want 0/%h/%0d",
                          k, lg_id[k], lg_dat[k], lg_cyc[k] - t0, 32'hB0 + k, exp_c[k]);
      end
    end
  endtask

  task automatic test_valid_gap();
    int t0;
    int exp_i [5] = '{0, 0, 0, 0, 1};
    int exp_d [5] = '{32'hC0, 32'hC1, 32'hC2, 32'hC3, 32'hD0};
    int exp_c [5] = '{1, 5, 6, 7, 9};
    clear_model();
    pkts[0] = 1; len[0] = 4; base[0] = 32'hC0;
    pkts[1] = 1; len[1] = 1; base[1] = 32'hD0;
    gap[1] = 1'b1;
    t0 = cyc;
    run(2);
    gap[1] = 1'b0;
    gap[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      ntests++; if (cur_rdy[1] !== 1'b0 || cur_wr_en !== 1'b0 || cur_gid !== 2'd0 || cur_busy !== 1'b1) begin
        nfail++; $display("FAIL gap_hold%0d rdy1=%0b wr_en=%0b gid=%0d busy=%0b want 0/0/0/1",
                          k, cur_rdy[1], cur_wr_en, cur_gid, cur_busy);
      end
    end
    gap[0] = 1'b0;
    run(5);
    ntests++; if (lg_id.size() !== 5) begin nfail++; $display("FAIL gap_count got %0d want 5", lg_id.size()); end
    for (int k = 0; k < 5 && k < lg_id.size(); k++) begin
      ntests++; if (lg_id[k] !== exp_i[k] || lg_dat[k] !== exp_d[k] || lg_cyc[k] !== t0 + exp_c[k]) begin
        nfail++; $display("FAIL gap_beat%0d id=%0d data=%h cyc=%0d want %0d/%h/%0d",
                          k, lg_id[k], lg_dat[k], lg_cyc[k] - t0, exp_i[k], exp_d[k], exp_c[k]);
      end
    end
  endtask

  // rr_ptr is 2 before this test; granting id 0 with all valid afterwards shows it was reset.
  task automatic test_reset_mid_burst();
    clear_model();
    pkts[0] = 1; len[0] = 5; base[0] = 32'hE0;
    run(3);
    rst = 1'b1;
    step();
    ntests++; if (cur_wr_en !== 1'b0 || cur_rdy !== 4'b0000) begin
      nfail++; $display("FAIL rstmid_cycle wr_en=%0b rdy=%b want 0/0000", cur_wr_en, cur_rdy);
    end
    rst = 1'b0;
    for (int i = 1; i < 4; i++) begin pkts[i] = 1; len[i] = 1; base[i] = i << 4; end
    step();
    ntests++; if (cur_busy !== 1'b0 || cur_wr_en !== 1'b0 || cur_gid !== 2'd0) begin
      nfail++; $display("FAIL rstmid_idle busy=%0b wr_en=%0b gid=%0d want 0/0/0", cur_busy, cur_wr_en, cur_gid);
    end
    step();
    ntests++; if (cur_wr_en !== 1'b1 || cur_id !== 2'd0 || cur_dat !== 32'hE2) begin
      nfail++; $display("FAIL rstmid_regrant wr_en=%0b id=%0d data=%h want 1/0/e2", cur_wr_en, cur_id, cur_dat);
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_data = '0; req_last = '0; fifo_full = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_requester();
    test_round_robin();
    test_max_burst();
    test_backpressure();
    test_valid_gap();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
